// File: rtl/cstuff_fifo.sv
// Elastic rdy/vld buffer between blockA and blockC with an APB status/control port.
// Exposes occupancy, high-water mark, pop count, plus flush and hold controls.
module cstuff_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_HWM    = 2'd1;
  localparam logic [1:0] A_XFER   = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  // Occupancy-style values are reported in an 8-bit field; clamp rather than wrap.
  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    return (w > 32'd255) ? 8'hFF : w[7:0];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr, rd_ptr, count, hwm;
  logic [CW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt, hwm_nxt;
  logic [15:0]   xfer, xfer_nxt;
  logic          hold, hold_nxt;

  logic access, wr_en, flush, push, pop;
  logic hwm_clr, xfer_clr, ctrl_wr;
  logic empty, full;

  logic unused_bits;
  assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:2]};

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign in_rdy   = rst_n && !full;
  assign out_vld  = rst_n && !empty && !hold;
  assign out_data = mem[rd_ptr[AW-1:0]];

  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  assign access   = psel && penable;
  assign wr_en    = access && pwrite;
  assign ctrl_wr  = wr_en && (paddr[3:2] == A_CTRL);
  assign hwm_clr  = wr_en && (paddr[3:2] == A_HWM);
  assign xfer_clr = wr_en && (paddr[3:2] == A_XFER);
  // The flush write itself empties the buffer, so a push in that cycle is dropped.
  assign flush    = ctrl_wr && pwdata[0];

  assign push = in_vld && in_rdy && !flush;
  assign pop  = out_vld && out_rdy;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      wr_ptr_nxt = wr_ptr + CW'(push);
      rd_ptr_nxt = rd_ptr + CW'(pop);
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // HWM tracks the post-update occupancy; a clear loads that same value.
  always_comb begin
    hwm_nxt = hwm;
    if (hwm_clr)
      hwm_nxt = count_nxt;
    else if (count_nxt > hwm)
      hwm_nxt = count_nxt;
  end

  always_comb begin
    xfer_nxt = xfer;
    if (xfer_clr)
      xfer_nxt = '0;
    else if (pop)
      xfer_nxt = xfer + 16'd1;
  end

  always_comb begin
    hold_nxt = hold;
    if (ctrl_wr)
      hold_nxt = pwdata[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hwm    <= '0;
      xfer   <= '0;
      hold   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      hwm    <= hwm_nxt;
      xfer   <= xfer_nxt;
      hold   <= hold_nxt;
    end
  end

  // Payload storage is left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_comb begin
    prdata = '0;
    if (access) begin
      case (paddr[3:2])
        A_STATUS: prdata = {14'd0, full, empty, 8'd0, sat8(count)};
        A_HWM:    prdata = {24'd0, sat8(hwm)};
        A_XFER:   prdata = {16'd0, xfer};
        A_CTRL:   prdata = {30'd0, hold, 1'b0};
        default:  prdata = '0;
      endcase
    end
  end

endmodule

// File: doc/cstuff_fifo.md
# cstuff_fifo

Elastic buffer on the `cStuffIf` rdy/vld path between `blockA` (producer) and `blockC` (consumer). It absorbs back-pressure from `blockC` with a circular buffer of configurable depth. It exposes occupancy, high-water mark and transfer-count status on an APB slave port hung off `apbDecode`. Flush and hold controls give firmware a way to drain or stall the path during bring-up.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, minimum 2.
- `DATA_W`, 8: payload width (packed `seeSt`).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_vld`  in  1  producer data valid.
- `in_rdy`  out  1  buffer can accept.
- `in_data`  in  DATA_W  producer payload.
- `out_vld`  out  1  buffer has data for consumer.
- `out_rdy`  in  1  consumer accepts.
- `out_data`  out  DATA_W  head-of-buffer payload.
- `psel`, `penable`, `pwrite`  in  1  APB control.
- `paddr`  in  32  APB byte address; only bits [3:2] are decoded, bits [31:4] are ignored.
- `pwdata`  in  32  APB write data.
- `prdata`  out  32  APB read data.
- `pready`  out  1  APB ready.
- `pslverr`  out  1  APB error.

## Operation
- Storage is DEPTH×DATA_W memory with wr_ptr and rd_ptr, each log2(DEPTH)+1 bits including a wrap bit. `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push occurs when `in_vld && in_rdy`. Pop occurs when `out_vld && out_rdy`. A simultaneous push and pop leaves `count` unchanged and moves both pointers.
- `in_rdy = rst_n && (count != DEPTH)`. It does not depend on `out_rdy`, so there is no full-bypass: a push presented while full is not accepted even if a pop happens in the same cycle.
- `out_vld = (count != 0) && !hold`. `out_data = mem[rd_ptr]`; it stays stable while `out_vld && !out_rdy`.
- There is no empty passthrough. Data pushed into an empty buffer appears at the output on the next cycle.
- APB registers, read with zero wait-state:
  - 0x0 STATUS (RO): [7:0] count, [16] empty, [17] full.
  - 0x4 HWM: [7:0] is the maximum `count` since the last clear. Any write clears it to the current post-update `count`. If a clear and an increase happen in the same cycle, the clear wins.
  - 0x8 XFER: [15:0] pop counter, wrapping 0xFFFF→0x0000. Any write clears it to 0. A pop in the same cycle as the clear is lost, and the counter reads 0.
  - 0xC CTRL: bit0 FLUSH is write-1 and self-clearing; it reads 0. Bit1 HOLD is R/W.
- FLUSH takes effect in the cycle after the write's access phase:
  - Pointers and `count` are zeroed.
  - A push in the flush cycle is discarded.
  - HWM and XFER are untouched.
- Writes to the RO register are ignored with `pslverr=0`.
- No unmapped address exists, because only bits [3:2] are decoded.
- Reset clears memory pointers, count, HWM, XFER and HOLD. Reset does not clear memory contents. Reset in mid-operation discards all buffered data.

## Timing
- Reset values of outputs: `in_rdy=0` while `rst_n=0`, and 1 on the first cycle after release. `out_vld=0`, `out_data` = don't-care, `prdata=0`, `pready=1`, `pslverr=0`.
- Push to `out_vld` latency is 1 cycle.
- Pop to freed slot: `in_rdy` rises the cycle after the pop that makes `count < DEPTH`.
- APB:
  - Setup phase is `psel && !penable`.
  - In the access phase (`psel && penable`), `pready=1` and `prdata` is driven combinationally from the current register state.
  - Writes commit at the end of the access-phase cycle.
  - `prdata=0` outside the access phase.
- HWM compares the next-state `count`, so a buffer that fills to DEPTH reads HWM=DEPTH on the cycle after the fill.
- HOLD forces `out_vld=0` starting the cycle after the CTRL write. Pushes continue until the buffer is full.

## Test plan
- Fill and drain, DEPTH=4: push A1..A4 with `out_rdy=0`. Required: `in_rdy=0` after the 4th push, STATUS=0x0002_0004, HWM=4. Then `out_rdy=1`: A1..A4 appear in order on 4 consecutive cycles, STATUS ends at 0x0001_0000, XFER=4.
- Full-buffer push and pop in the same cycle: with count=4, `in_vld=1`, `out_rdy=1`. Required: the pop is taken and the push is rejected; the next cycle has count=3 and `in_rdy=1`.
- Streaming: `in_vld=out_rdy=1` continuously for 100 cycles. Required: after the first cycle `out_vld` stays at 1, HWM ≤ 2, and XFER=99 at the end.
- FLUSH: with 3 entries buffered, write CTRL=0x1 while `in_vld=1`. Required: the next cycle has count=0, `out_vld=0`, and the pushed word is absent; XFER and HWM are unchanged.
- HOLD and XFER wrap: preload XFER to 0xFFFF by running 65535 pops, set HOLD, push 2 words. Required: `out_vld` stays 0. Then clear HOLD and pop 1. Required: XFER=0x0000 and count=1.
- Reset mid-stream: assert `rst_n=0` for 1 cycle with 2 entries buffered. Required: `in_rdy=0` during reset, then count=0, HWM=0, HOLD=0, and `in_rdy=1` on release.
